dmem_arbiter: RTL

- Two-port arbiter and access sequencer in front of the word-wide data memory.
- The data memory has a combinational read, a synchronous write, and no byte enables.
- Shares it between requester 0 (core load/store stage) and requester 1 (debug/DMA loader) using round-robin priority.
- Performs byte-masked stores as a read-modify-write sequence and returns registered read data with a one-cycle done pulse.

---
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer sharing one word-wide data memory
// between two requesters; partial-byte stores become read-modify-write.
module dmem_arbiter #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [3:0]    m0_be,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_done,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [3:0]    m1_be,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_done,
    output logic [31:0]   m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wd,
    output logic          mem_we,
    input  logic [31:0]   mem_rd
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          sel_q, sel_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          g_we;
    logic [3:0]    g_be;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        sel_d    = sel_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        m0_gnt   = 1'b0;
        m1_gnt   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        g_we     = m1_gnt ? m1_we : m0_we;
        g_be     = m0_be;

        case (state_q)
            IDLE: begin
                if (!rst) begin
                    // On a tie the requester that did not win last time goes first
                    m0_gnt = m0_req & (~m1_req | last_q);
                    m1_gnt = m1_req & (~m0_req | ~last_q);
                end
                g_we = m1_gnt ? m1_we : m0_we;
                g_be = m1_gnt ? m1_be : m0_be;
                if (m0_gnt || m1_gnt) begin
                    sel_d   = m1_gnt;
                    last_d  = m1_gnt;
                    we_d    = g_we;
                    be_d    = g_be;
                    addr_d  = m1_gnt ? m1_addr : m0_addr;
                    wdata_d = m1_gnt ? m1_wdata : m0_wdata;
                    rdata_d = '0;
                    if (!g_we)
                        state_d = RD;
                    else if (g_be == 4'hF)
                        state_d = WR;
                    else if (g_be == 4'h0)
                        state_d = DONE;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                mem_addr = addr_q;
                rdata_d  = mem_rd;
                state_d  = we_q ? WR : DONE;
            end
            WR: begin
                // Old word sits in rdata_q for RMW; full stores take every byte from wdata
                mem_addr = addr_q;
                for (int unsigned i = 0; i < 4; i++)
                    mem_wd[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : rdata_q[8*i +: 8];
                rdata_d = '0;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_we   = (state_q == WR) & ~rst;
    assign m0_done  = (state_q == DONE) & ~sel_q & ~rst;
    assign m1_done  = (state_q == DONE) & sel_q & ~rst;
    assign m0_rdata = rdata_q;
    assign m1_rdata = rdata_q;

endmodule
